// File: rtl/sram_responder_if.sv
// Request/response bus between the MEM stage and sram_responder, plus the
// per-chip asynchronous SRAM pin bundle (tri-state buffers live at top level).
interface sram_req_if;
  logic        req_read;
  logic        req_write;
  logic        req_ext;
  logic [19:0] req_adr;
  logic [3:0]  req_be_n;
  logic [31:0] req_wdata;
  logic        req_signed;
  logic        busy;
  logic        done;
  logic [31:0] rdata;

  modport master (output req_read, req_write, req_ext, req_adr, req_be_n, req_wdata, req_signed,
                  input  busy, done, rdata);
  modport slave  (input  req_read, req_write, req_ext, req_adr, req_be_n, req_wdata, req_signed,
                  output busy, done, rdata);
endinterface

interface sram_pin_if;
  logic [19:0] addr;
  logic [3:0]  be_n;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic [31:0] data_o;
  logic        data_oe;
  logic [31:0] data_i;

  modport master (output addr, be_n, ce_n, oe_n, we_n, data_o, data_oe, input data_i);
  modport slave  (input  addr, be_n, ce_n, oe_n, we_n, data_o, data_oe, output data_i);
endinterface

// File: rtl/sram_responder.sv
// Timed read/write cycle engine for the base/ext 1M x 32 asynchronous SRAMs.
// Optional macro SRAM_LOAD_ALIGN_EN: align/sign-extend loaded bytes/halves from the latched be_n.
module sram_responder #(
  parameter int READ_WAIT = 2,
  parameter int WE_PULSE  = 2
) (
  input  logic        clk,
  input  logic        rst,
  sram_req_if.slave   req,
  sram_pin_if.master  base_ram,
  sram_pin_if.master  ext_ram
);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  localparam logic [2:0] RW_LAST = 3'(READ_WAIT);
  localparam logic [2:0] WP_LAST = 3'(WE_PULSE);

  state_t      state;
  logic [2:0]  cnt;
  logic        ext_q;
  logic [19:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        ce_n_q, oe_n_q, we_n_q, doe_q;
  logic        busy_q, done_q;
  logic [31:0] rdata_q;
  logic [31:0] raw_in;
  logic [31:0] load_data;

  assign raw_in = ext_q ? ext_ram.data_i : base_ram.data_i;

`ifdef SRAM_LOAD_ALIGN_EN
  logic sign_q;

  function automatic logic [31:0] load_align(input logic [31:0] raw, input logic [3:0] be_n,
                                             input logic sgn);
    logic [31:0] v;
    v = raw;
    case (be_n)
      4'b1110: v = {{24{sgn & raw[7]}},  raw[7:0]};
      4'b1101: v = {{24{sgn & raw[15]}}, raw[15:8]};
      4'b1011: v = {{24{sgn & raw[23]}}, raw[23:16]};
      4'b0111: v = {{24{sgn & raw[31]}}, raw[31:24]};
      4'b1100: v = {{16{sgn & raw[15]}}, raw[15:0]};
      4'b0011: v = {{16{sgn & raw[31]}}, raw[31:16]};
      default: v = raw;
    endcase
    return v;
  endfunction

  assign load_data = load_align(raw_in, be_q, sign_q);
`else
  assign load_data = raw_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      ext_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'hF;
      wdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
`ifdef SRAM_LOAD_ALIGN_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req.req_read | req.req_write) begin
            ext_q   <= req.req_ext;
            addr_q  <= req.req_adr;
            be_q    <= req.req_be_n;
            wdata_q <= req.req_wdata;
`ifdef SRAM_LOAD_ALIGN_EN
            sign_q  <= req.req_signed;
`endif
            busy_q  <= 1'b1;
            cnt     <= 3'd1;
            ce_n_q  <= 1'b0;
            // Write wins when both are raised.
            if (req.req_write) begin
              state <= WR_SETUP;
              doe_q <= 1'b1;
            end else begin
              state  <= RD;
              oe_n_q <= 1'b0;
            end
          end
        end
        RD: begin
          if (cnt >= RW_LAST) begin
            rdata_q <= load_data;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WR_SETUP: begin
          we_n_q <= 1'b0;
          cnt    <= 3'd1;
          state  <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt >= WP_LAST) begin
            we_n_q <= 1'b1;
            state  <= WR_HOLD;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WR_HOLD: begin
          ce_n_q <= 1'b1;
          doe_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req.busy  = busy_q;
  assign req.done  = done_q;
  assign req.rdata = rdata_q;

  // Unselected chip sees constant idle values.
  assign base_ram.addr    = ext_q ? 20'd0  : addr_q;
  assign base_ram.be_n    = ext_q ? 4'hF   : be_q;
  assign base_ram.ce_n    = ext_q ? 1'b1   : ce_n_q;
  assign base_ram.oe_n    = ext_q ? 1'b1   : oe_n_q;
  assign base_ram.we_n    = ext_q ? 1'b1   : we_n_q;
  assign base_ram.data_o  = ext_q ? 32'd0  : wdata_q;
  assign base_ram.data_oe = ext_q ? 1'b0   : doe_q;

  assign ext_ram.addr     = ext_q ? addr_q  : 20'd0;
  assign ext_ram.be_n     = ext_q ? be_q    : 4'hF;
  assign ext_ram.ce_n     = ext_q ? ce_n_q  : 1'b1;
  assign ext_ram.oe_n     = ext_q ? oe_n_q  : 1'b1;
  assign ext_ram.we_n     = ext_q ? we_n_q  : 1'b1;
  assign ext_ram.data_o   = ext_q ? wdata_q : 32'd0;
  assign ext_ram.data_oe  = ext_q ? doe_q   : 1'b0;
endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench for sram_responder against a cycle-timeline reference model.
module tb_sram_responder;
  localparam int RW = 2;
  localparam int WP = 2;
`ifdef SRAM_LOAD_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_req_if rq();
  sram_pin_if bp();
  sram_pin_if ep();

  sram_responder #(.READ_WAIT(RW), .WE_PULSE(WP)) dut (
    .clk(clk), .rst(rst), .req(rq), .base_ram(bp), .ext_ram(ep)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] last_rdata = 32'd0;

  logic [3:0] b_str, e_str;
  assign b_str = {bp.ce_n, bp.oe_n, bp.we_n, bp.data_oe};
  assign e_str = {ep.ce_n, ep.oe_n, ep.we_n, ep.data_oe};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected load result from the byte-lane rules.
  function automatic logic [31:0] exp_load(input logic [31:0] raw, input logic [3:0] be,
                                           input logic sgn);
    int sh;
    int w;
    logic [31:0] v, mask;
    if (!ALIGN) return raw;
    sh = -1;
    w = 8;
    case (be)
      4'b1110: sh = 0;
      4'b1101: sh = 8;
      4'b1011: sh = 16;
      4'b0111: sh = 24;
      4'b1100: begin sh = 0;  w = 16; end
      4'b0011: begin sh = 16; w = 16; end
      default: sh = -1;
    endcase
    if (sh < 0) return raw;
    mask = (w == 8) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (raw >> sh) & mask;
    if (sgn && v[w-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic check_pins(input string tag, input logic ext, input logic [3:0] str,
                            input logic [19:0] adr, input logic [3:0] be,
                            input logic chk_data, input logic [31:0] wd);
    logic [3:0] s_str, u_str, s_be, u_be;
    logic [19:0] s_addr, u_addr;
    logic [31:0] s_do, u_do;
    s_str = ext ? e_str : b_str;  u_str = ext ? b_str : e_str;
    s_addr = ext ? ep.addr : bp.addr;  u_addr = ext ? bp.addr : ep.addr;
    s_be = ext ? ep.be_n : bp.be_n;  u_be = ext ? bp.be_n : ep.be_n;
    s_do = ext ? ep.data_o : bp.data_o;  u_do = ext ? bp.data_o : ep.data_o;
    chk({tag, "_str"}, 32'(s_str), 32'(str));
    if (!str[3]) begin
      chk({tag, "_addr"}, 32'(s_addr), 32'(adr));
      chk({tag, "_be"}, 32'(s_be), 32'(be));
    end
    if (chk_data) chk({tag, "_wdata"}, s_do, wd);
    chk({tag, "_unsel_str"}, 32'(u_str), 32'h0000_000E);
    chk({tag, "_unsel_addr"}, 32'(u_addr), 32'd0);
    chk({tag, "_unsel_be"}, 32'(u_be), 32'h0000_000F);
    chk({tag, "_unsel_do"}, u_do, 32'd0);
    chk({tag, "_oe_clash"}, {30'd0, !bp.oe_n && bp.data_oe, !ep.oe_n && ep.data_oe}, 32'd0);
  endtask

  // One request issued in the IDLE cycle following the caller's last negedge.
  task automatic txn(input logic rd, input logic wr, input logic ext, input logic [19:0] adr,
                     input logic [3:0] be, input logic [31:0] wd, input logic sgn,
                     input logic [31:0] raw, input logic hold, input string tag);
    logic is_wr;
    int n;
    logic [3:0] str;
    is_wr = wr;
    n = is_wr ? WP + 3 : RW + 1;
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, rq.busy, rq.done}, 32'd0);
    rq.req_read = rd;  rq.req_write = wr;  rq.req_ext = ext;  rq.req_adr = adr;
    rq.req_be_n = be;  rq.req_wdata = wd;  rq.req_signed = sgn;
    bp.data_i = ext ? $urandom : raw;
    ep.data_i = ext ? raw : $urandom;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == n) str = 4'b1110;
      else if (!is_wr) str = 4'b0010;
      else if (k == 1 || k == WP + 2) str = 4'b0111;
      else str = 4'b0101;
      check_pins($sformatf("%s_c%0d", tag, k), ext, str, adr, be, is_wr && k < n, wd);
      chk($sformatf("%s_c%0d_bd", tag, k), {30'd0, rq.busy, rq.done},
          (k == n) ? 32'd1 : 32'd2);
      if (k == n) begin
        if (!is_wr) last_rdata = exp_load(raw, be, sgn);
        chk({tag, "_rdata"}, rq.rdata, last_rdata);
      end
      rq.req_ext = 1'($urandom);  rq.req_adr = 20'($urandom);
      rq.req_be_n = 4'($urandom);  rq.req_wdata = $urandom;  rq.req_signed = 1'($urandom);
      if (k < n) begin
        rq.req_read = 1'($urandom);  rq.req_write = 1'($urandom);
      end else begin
        rq.req_read = hold;  rq.req_write = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] be_tab [8];
    logic [3:0] be;
    logic rd, wr;
    be_tab = '{4'b0000, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1100, 4'b0011, 4'b1010};
    rst = 1'b1;
    rq.req_read = 0; rq.req_write = 0; rq.req_ext = 0; rq.req_adr = 0;
    rq.req_be_n = 0; rq.req_wdata = 0; rq.req_signed = 0;
    bp.data_i = 0; ep.data_i = 0;
    #1;
    chk("rst_bd", {30'd0, rq.busy, rq.done}, 32'd0);
    chk("rst_rdata", rq.rdata, 32'd0);
    check_pins("rst", 1'b0, 4'b1110, 20'd0, 4'hF, 1'b1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    txn(1, 0, 0, 20'h00012, 4'b0000, 32'h0, 0, 32'hDEADBEEF, 0, "base_word_rd");
    txn(0, 1, 1, 20'h00100, 4'b1011, 32'h00A50000, 0, 32'h0, 0, "ext_byte_wr");
    txn(1, 0, 0, 20'h00040, 4'b0111, 32'h0, 1, 32'h80123456, 0, "rd_b3_s");
    txn(1, 0, 0, 20'h00041, 4'b0111, 32'h0, 0, 32'h80123456, 0, "rd_b3_u");
    txn(1, 0, 0, 20'h00042, 4'b1100, 32'h0, 1, 32'h1234F00D, 0, "rd_h0_s");
    txn(1, 1, 1, 20'h00077, 4'b0000, 32'hCAFEF00D, 0, 32'h0, 1, "rd_wr_both");
    txn(1, 0, 1, 20'h00333, 4'b1101, 32'h0, 1, 32'h0000_8000, 1, "held_rd0");
    txn(1, 0, 1, 20'h00334, 4'b1110, 32'h0, 0, 32'h0000_00FF, 1, "held_rd1");
    txn(1, 0, 0, 20'hFFFFF, 4'b0011, 32'h0, 1, 32'h9ABC_0000, 0, "held_rd2");

    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      be = be_tab[$urandom_range(0, 7)];
      txn(rd, wr, 1'($urandom), 20'($urandom), be, $urandom, 1'($urandom), $urandom,
          1'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of the write pulse.
    @(negedge clk);
    rq.req_read = 0; rq.req_write = 1; rq.req_ext = 1; rq.req_adr = 20'h00ABC;
    rq.req_be_n = 4'b0000; rq.req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pulse_we", 32'(ep.we_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ext_str", 32'(e_str), 32'h0000_000E);
    chk("midrst_base_str", 32'(b_str), 32'h0000_000E);
    chk("midrst_bd", {30'd0, rq.busy, rq.done}, 32'd0);
    rq.req_write = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_nodone%0d", k), {30'd0, rq.busy, rq.done}, 32'd0);
    end
    chk("midrst_rdata", rq.rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
